// File: rtl/audio_fifo_wb_if.sv
// Bus and audio-stream signals of the audio FIFO, grouped for one connection.
// The master side is the bus controller plus the encoder; the slave is the FIFO.
interface audio_fifo_wb_if #(
  parameter int SW = 16
) ();
  logic [3:0]    wb_addr;
  logic [31:0]   wb_wdata;
  logic [31:0]   wb_rdata;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_ack;
  logic [SW-1:0] audio_l;
  logic [SW-1:0] audio_r;
  logic          audio_ack;
  logic          irq_low;

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc, audio_ack,
    output wb_rdata, wb_ack, audio_l, audio_r, irq_low
  );

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc, audio_ack,
    input  wb_rdata, wb_ack, audio_l, audio_r, irq_low
  );
endinterface

// File: rtl/audio_fifo_wb.sv
// Stereo audio sample FIFO with a four-register bus slave. Feeds an encoder
// with silence, a ramp test pattern, or FIFO data (stereo or mono pushes).
// Bus side effects happen on the accept cycle; the ack follows one cycle later.
module audio_fifo_wb #(
  parameter int          DEPTH_LOG2   = 9,
  parameter int          SW           = 16,
  parameter logic [15:0] RAMP_INC_RST = 16'd1024
) (
  input logic            clk,
  input logic            rst,
  audio_fifo_wb_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;

  // Keep the top SW bits of a 16-bit sample field.
  function automatic logic [SW-1:0] take(input logic [15:0] f);
    return f[15 -: SW];
  endfunction

  logic [2*SW-1:0] mem_q [DEPTH];
  ptr_t            wp_q, wp_d, rp_q, rp_d;
  lvl_t            level_q, level_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     inc_q, inc_d, ramp_q, ramp_d, thresh_q, thresh_d;
  logic            unf_q, unf_d, ovf_q, ovf_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [SW-1:0]   al_q, al_d, ar_q, ar_d;

  logic            acc, wr, csr_wr, flush, push, pop, empty, full;
  logic            pop_ok, push_ok, unf_set, ovf_set;
  logic [1:0]      a;
  logic [31:0]     w;
  logic [2*SW-1:0] push_data;
  logic            unused_addr;

  assign unused_addr = ^bus.wb_addr[3:2];
  assign a       = bus.wb_addr[1:0];
  assign w       = bus.wb_wdata;
  // An access is accepted only while no ack is outstanding, so acks never repeat back to back.
  assign acc     = bus.wb_cyc & ~ack_q;
  assign wr      = acc & bus.wb_we;
  assign csr_wr  = wr & (a == 2'd0);
  assign flush   = csr_wr & w[2];
  assign push    = wr & (a == 2'd1);
  assign pop     = bus.audio_ack & mode_q[1];
  assign empty   = (level_q == '0);
  assign full    = (level_q == lvl_t'(DEPTH));
  // A flushing pop sees an empty FIFO; no bypass from a same-cycle push.
  assign pop_ok  = pop & ~empty & ~flush;
  assign unf_set = pop & (empty | flush);
  assign push_ok = push & ~flush & ~full;
  assign ovf_set = push & ~flush & full;
  assign push_data = (mode_q == 2'd3) ? {take(w[15:0]), take(w[15:0])}
                                      : {take(w[31:16]), take(w[15:0])};

  assign bus.wb_ack   = ack_q;
  assign bus.wb_rdata = rdata_q;
  assign bus.audio_l  = al_q;
  assign bus.audio_r  = ar_q;
  assign bus.irq_low  = mode_q[1] & (16'(level_q) < thresh_q);

  // Next-state for bus registers, FIFO bookkeeping and the output sample pair.
  always_comb begin
    ack_d    = acc;
    rdata_d  = '0;
    if (acc && !bus.wb_we) begin
      case (a)
        2'd0:    rdata_d = {inc_q, 11'd0, ovf_q, unf_q, 1'b0, mode_q};
        2'd2:    rdata_d = {12'd0, ovf_q, unf_q, full, empty, 16'(level_q)};
        2'd3:    rdata_d = {16'd0, thresh_q};
        default: rdata_d = '0;
      endcase
    end

    mode_d   = mode_q;
    inc_d    = inc_q;
    thresh_d = thresh_q;
    if (csr_wr) begin
      mode_d = w[1:0];
      inc_d  = w[31:16];
    end
    if (wr && (a == 2'd3)) thresh_d = w[15:0];

    unf_d = (unf_q & ~(csr_wr & w[3])) | unf_set;
    ovf_d = (ovf_q & ~(csr_wr & w[4])) | ovf_set;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      wp_d    = wp_q + ptr_t'(push_ok);
      rp_d    = rp_q + ptr_t'(pop_ok);
      level_d = level_q + lvl_t'(push_ok) - lvl_t'(pop_ok);
    end

    ramp_d = ramp_q;
    al_d   = al_q;
    ar_d   = ar_q;
    if (bus.audio_ack) begin
      case (mode_q)
        2'd0: begin
          al_d = '0;
          ar_d = '0;
        end
        2'd1: begin
          ramp_d = ramp_q + inc_q;
          al_d   = take(ramp_d);
          ar_d   = take(ramp_d);
        end
        default: begin
          if (pop_ok) {al_d, ar_d} = mem_q[rp_q];
          else begin
            al_d = '0;
            ar_d = '0;
          end
        end
      endcase
    end
  end

  // State registers; reset clears everything, aborting any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      mode_q   <= 2'd0;
      inc_q    <= RAMP_INC_RST;
      thresh_q <= '0;
      ramp_q   <= '0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      level_q  <= '0;
      al_q     <= '0;
      ar_q     <= '0;
    end else begin
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      mode_q   <= mode_d;
      inc_q    <= inc_d;
      thresh_q <= thresh_d;
      ramp_q   <= ramp_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      level_q  <= level_d;
      al_q     <= al_d;
      ar_q     <= ar_d;
    end
  end

  // Sample storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= push_data;
  end
endmodule

// File: tb/tb_audio_fifo_wb.sv
// Directed bench for audio_fifo_wb with a 4-entry FIFO and 16-bit samples.
module tb_audio_fifo_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rd;
  logic        ak;

  audio_fifo_wb_if #(.SW(16)) bif ();

  audio_fifo_wb #(.DEPTH_LOG2(2), .SW(16), .RAMP_INC_RST(16'd1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic we, input logic [31:0] d,
                     output logic [31:0] r, output logic k);
    @(negedge clk);
    bif.wb_addr = a; bif.wb_we = we; bif.wb_wdata = d; bif.wb_cyc = 1'b1;
    @(negedge clk);
    bif.wb_cyc = 1'b0; bif.wb_we = 1'b0;
    k = bif.wb_ack;
    r = bif.wb_rdata;
  endtask

  task automatic wr(input string tag, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic k;
    bus(a, 1'b1, d, r, k);
    chk({tag, "_ack"}, {31'd0, k}, 32'd1);
  endtask

  task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic k;
    bus(a, 1'b0, 32'd0, r, k);
    chk({tag, "_ack"}, {31'd0, k}, 32'd1);
    chk(tag, r, exp);
  endtask

  task automatic aack();
    @(negedge clk); bif.audio_ack = 1'b1;
    @(negedge clk); bif.audio_ack = 1'b0;
  endtask

  task automatic push_ack(input logic [31:0] d);
    @(negedge clk);
    bif.wb_addr = 4'd1; bif.wb_we = 1'b1; bif.wb_wdata = d; bif.wb_cyc = 1'b1;
    bif.audio_ack = 1'b1;
    @(negedge clk);
    bif.wb_cyc = 1'b0; bif.wb_we = 1'b0; bif.audio_ack = 1'b0;
  endtask

  function automatic logic [31:0] pair();
    return {bif.audio_l, bif.audio_r};
  endfunction

  initial begin
    bif.wb_addr = '0; bif.wb_wdata = '0; bif.wb_we = 1'b0; bif.wb_cyc = 1'b0;
    bif.audio_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ack", {31'd0, bif.wb_ack}, 32'd0);
    chk("rst_rdata", bif.wb_rdata, 32'd0);
    chk("rst_audio", pair(), 32'd0);
    chk("rst_irq", {31'd0, bif.irq_low}, 32'd0);
    rdchk("rst_status", 4'd2, 32'h0001_0000);
    rdchk("rst_csr", 4'd0, 32'h0400_0000);

    // Ramp mode
    wr("csr_ramp", 4'd0, 32'h0400_0001);
    aack(); chk("ramp1", pair(), 32'h0400_0400);
    aack(); chk("ramp2", pair(), 32'h0800_0800);
    aack(); chk("ramp3", pair(), 32'h0C00_0C00);

    // Stereo FIFO, underrun and its clear
    wr("csr_stereo", 4'd0, 32'h0400_0002);
    wr("push_a", 4'd1, 32'h1111_2222);
    wr("push_b", 4'd1, 32'h3333_4444);
    rdchk("status_lvl2", 4'd2, 32'h0000_0002);
    aack(); chk("pop_a", pair(), 32'h1111_2222);
    aack(); chk("pop_b", pair(), 32'h3333_4444);
    aack(); chk("pop_empty", pair(), 32'h0000_0000);
    rdchk("status_unf", 4'd2, 32'h0005_0000);
    wr("clr_unf", 4'd0, 32'h0400_000A);
    rdchk("status_unf_clr", 4'd2, 32'h0001_0000);

    // Overflow on a full FIFO
    for (int i = 1; i <= 5; i++) wr("push_ovf", 4'd1, {16'hA000 + 16'(i), 16'hB000 + 16'(i)});
    rdchk("status_full", 4'd2, 32'h000A_0004);
    for (int i = 1; i <= 4; i++) begin
      aack(); chk("pop_full", pair(), {16'hA000 + 16'(i), 16'hB000 + 16'(i)});
    end
    aack(); chk("pop_no5th", pair(), 32'h0000_0000);
    rdchk("status_ovf_unf", 4'd2, 32'h000D_0000);
    wr("clr_both", 4'd0, 32'h0400_001A);
    rdchk("status_clr_both", 4'd2, 32'h0001_0000);

    // Simultaneous push and pop
    wr("push_c", 4'd1, 32'h5555_6666);
    push_ack(32'h7777_8888);
    chk("sim_ack", {31'd0, bif.wb_ack}, 32'd1);
    chk("sim_head", pair(), 32'h5555_6666);
    rdchk("sim_level", 4'd2, 32'h0000_0001);
    aack(); chk("sim_next", pair(), 32'h7777_8888);
    rdchk("sim_empty", 4'd2, 32'h0001_0000);
    push_ack(32'h9999_AAAA);
    chk("nobypass_out", pair(), 32'h0000_0000);
    rdchk("nobypass_status", 4'd2, 32'h0004_0001);
    wr("flush_clr", 4'd0, 32'h0400_000E);
    rdchk("status_flushed", 4'd2, 32'h0001_0000);

    // Threshold, mono, flush
    wr("thresh", 4'd3, 32'h0000_0002);
    rdchk("thresh_rd", 4'd3, 32'h0000_0002);
    wr("csr_mono", 4'd0, 32'h0400_0003);
    chk("irq_empty", {31'd0, bif.irq_low}, 32'd1);
    wr("push_mono", 4'd1, 32'h0000_ABCD);
    chk("irq_lvl1", {31'd0, bif.irq_low}, 32'd1);
    aack(); chk("mono_out", pair(), 32'hABCD_ABCD);
    wr("push_m2", 4'd1, 32'h0000_1234);
    wr("push_m3", 4'd1, 32'h0000_5678);
    chk("irq_lvl2", {31'd0, bif.irq_low}, 32'd0);
    wr("flush", 4'd0, 32'h0400_0007);
    rdchk("flush_status", 4'd2, 32'h0001_0000);
    chk("irq_flush", {31'd0, bif.irq_low}, 32'd1);
    chk("flush_keeps_out", pair(), 32'hABCD_ABCD);

    // Silence, DATA read, alias decode, held cycle
    wr("csr_silence", 4'd0, 32'h0400_0000);
    chk("irq_silence", {31'd0, bif.irq_low}, 32'd0);
    aack(); chk("silence_out", pair(), 32'h0000_0000);
    rdchk("data_rd", 4'd1, 32'h0000_0000);
    rdchk("alias_status", 4'h6, 32'h0001_0000);
    @(negedge clk);
    bif.wb_addr = 4'd3; bif.wb_we = 1'b0; bif.wb_cyc = 1'b1;
    @(negedge clk);
    chk("held_ack1", {31'd0, bif.wb_ack}, 32'd1);
    chk("held_rd1", bif.wb_rdata, 32'h0000_0002);
    @(negedge clk);
    bif.wb_cyc = 1'b0;
    chk("held_ack2", {31'd0, bif.wb_ack}, 32'd0);
    chk("held_rd2", bif.wb_rdata, 32'h0000_0000);
    @(negedge clk);

    // Ramp value survives mode changes
    wr("csr_ramp2", 4'd0, 32'h0400_0001);
    aack(); chk("ramp_keep", pair(), 32'h1000_1000);

    // Reset during an access
    @(negedge clk);
    bif.wb_addr = 4'd3; bif.wb_we = 1'b1; bif.wb_wdata = 32'h0000_0005; bif.wb_cyc = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bif.wb_cyc = 1'b0; bif.wb_we = 1'b0; rst = 1'b0;
    chk("rst_abort_ack", {31'd0, bif.wb_ack}, 32'd0);
    chk("rst_abort_audio", pair(), 32'h0000_0000);
    rdchk("rst_abort_thresh", 4'd3, 32'h0000_0000);
    rdchk("rst_abort_csr", 4'd0, 32'h0400_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_fifo_wb.md
AUDIO_FIFO_WB -- requirements
Module: audio_fifo_wb

Interface
REQ-001 Parameter DEPTH_LOG2, default 9, sets FIFO depth to 2^DEPTH_LOG2 stereo entries.
REQ-002 Parameter SW, default 16, sets the per-channel sample width, 8..16.
REQ-003 Parameter RAMP_INC_RST, default 16'd1024, sets the reset value of the ramp increment.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wb_addr  in  4  word address; only [1:0] decoded, [3:2] ignored.
REQ-007 wb_wdata  in  32  write data.
REQ-008 wb_rdata  out  32  read data.
REQ-009 wb_we  in  1  write strobe.
REQ-010 wb_cyc  in  1  cycle/select.
REQ-011 wb_ack  out  1  single-cycle acknowledge.
REQ-012 audio_l  out  SW  left sample presented to the encoder.
REQ-013 audio_r  out  SW  right sample presented to the encoder.
REQ-014 audio_ack  in  1  encoder consumed the current sample pair.
REQ-015 irq_low  out  1  FIFO level below the programmed threshold while in a FIFO mode.

Function
REQ-016 Bus handshake: wb_ack = 1 exactly one cycle after wb_cyc is seen high with wb_ack low; it is never asserted two consecutive cycles; each access has exactly one side effect.
REQ-017 wb_rdata is 0 whenever wb_ack = 0.
REQ-018 Reg 0, CSR (R/W):
- [1:0] MODE: 0 silence, 1 ramp, 2 FIFO stereo, 3 FIFO mono.
- [2] flush, write-1 action, reads 0.
- [3] underrun sticky, write-1-clear.
- [4] overflow sticky, write-1-clear.
- [31:16] ramp increment.
REQ-019 Reg 1, DATA: write pushes one entry; stereo = {L=wdata[31:16], R=wdata[15:0]}; mono = wdata[15:0] to both channels. Read returns 0.
REQ-020 Reg 2, STATUS (RO): [15:0] level, zero-extended; [16] empty; [17] full; [18] underrun; [19] overflow.
REQ-021 Reg 3, THRESH (R/W): [15:0] low-water threshold; irq_low = FIFO mode & (level < THRESH).
REQ-022 Samples are taken from the top SW bits of each 16-bit field, so the lower 16-SW bits are dropped.
REQ-023 Level is DEPTH_LOG2+1 bits wide; full when level = 2^DEPTH_LOG2; read/write pointers wrap modulo depth.
REQ-024 audio_l/audio_r are registers holding the current pair; on audio_ack the next pair is loaded and visible the following cycle (latency 1).
REQ-025 Next pair on ack, by mode:
- mode 0: zero.
- mode 1: ramp <= ramp + increment, mod 2^16; both channels = new ramp.
- modes 2/3 with FIFO non-empty: pop head.
- modes 2/3 with FIFO empty: zero pair, underrun set.
REQ-026 A push while full is dropped and sets overflow; level unchanged.
REQ-027 A push and a pop in the same cycle both take effect; level unchanged.
REQ-028 A pop while empty is not satisfied by a same-cycle push (no bypass); underrun is set and the push is stored.
REQ-029 Flush zeroes both pointers and level; it does not change audio_l/r; a same-cycle push is discarded without setting overflow; a same-cycle pop takes the empty rule.
REQ-030 A MODE change preserves FIFO contents and ramp value; the new mode applies from the next audio_ack.
REQ-031 A sticky flag set and a W1C of that flag in the same cycle leave the flag set.
REQ-032 Implementation may infer EBR; the cycle behaviour above is mandatory regardless.

Reset
REQ-033 On rst: wb_ack=0, wb_rdata=0, audio_l=audio_r=0, irq_low=0, MODE=0, ramp=0, increment=RAMP_INC_RST, THRESH=0, pointers/level=0, sticky flags=0.
REQ-034 rst asserted mid bus access aborts the access with no ack and no side effect; rst mid-stream discards FIFO contents.

Verification
REQ-035 Reset, read reg 2 -> 0x0001_0000 (empty); read reg 0 -> 0x0400_0000; audio_l=audio_r=0.
REQ-036 MODE=1, increment 1024, three audio_ack pulses -> audio_l=audio_r = 0x0400, 0x0800, 0x0C00, each one cycle after its ack.
REQ-037 MODE=2, push 0x1111_2222 then 0x3333_4444, ack x3 -> (0x1111,0x2222), (0x3333,0x4444), then (0,0); STATUS[18]=1; write CSR bit3 -> STATUS[18]=0.
REQ-038 DEPTH_LOG2=2: push 5 entries -> level 4, full=1, overflow=1; 5th value never appears at the outputs.
REQ-039 Level 1, push and ack in the same cycle -> level stays 1, output = old head; on an empty FIFO the same stimulus -> underrun=1, level 1.
REQ-040 THRESH=2, MODE=3, push 0x0000_ABCD -> irq_low=1, audio_l=audio_r=0xABCD after ack; push 2 more -> irq_low=0; flush -> level 0, irq_low=1.
